// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, next-PC selection and the IF/ID pipeline register.
// Optional perf counters are compiled in when FETCH_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  Branch_Taken_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic                  Jump_i,
    input  logic [25:0]           Jump_Index_i,
    input  logic                  Jump_Reg_i,
    input  logic [DATA_WIDTH-1:0] Jump_Reg_Addr_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_Plus4_o,
    output logic                  IF_ID_Valid_o,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0]           Fetch_Count_o,
    output logic [31:0]           Bubble_Count_o,
`endif
    output logic                  Fetch_Error_o
);

    // One extra bit so the upper bound cannot overflow near the top of memory.
    localparam logic [DATA_WIDTH:0] TEXT_LIMIT =
        {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic                  fetch_err_q, fetch_err_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jump_target;
    logic                  fault;
    logic                  redirect;
    logic                  load_valid;
    logic                  load_bubble;

    assign pc_plus4    = pc_q + DATA_WIDTH'(4);
    assign jump_target = {ifid_pc4_q[DATA_WIDTH-1:DATA_WIDTH-4], Jump_Index_i, 2'b00};
    assign fault       = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_BASE) ||
                         ({1'b0, pc_q} >= TEXT_LIMIT);
    assign redirect    = (Jump_Reg_i || Jump_i || Branch_Taken_i) && !Stall_i;

    always_comb begin
        pc_d         = pc_plus4;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_err_d  = fetch_err_q;
        load_valid   = 1'b0;
        load_bubble  = 1'b0;

        // A fault freezes the PC at the offending address until reset.
        if (fetch_err_q || Stall_i || fault) begin
            pc_d = pc_q;
        end else if (Jump_Reg_i) begin
            pc_d = Jump_Reg_Addr_i;
        end else if (Jump_i) begin
            pc_d = jump_target;
        end else if (Branch_Taken_i) begin
            pc_d = Branch_Target_i;
        end

        if (fault && !Stall_i) begin
            fetch_err_d = 1'b1;
        end

        if (Flush_i) begin
            ifid_instr_d = NOP_WORD;
            ifid_valid_d = 1'b0;
            load_bubble  = 1'b1;
        end else if (Stall_i) begin
            ifid_instr_d = ifid_instr_q;
        end else if (fault) begin
            ifid_instr_d = NOP_WORD;
            ifid_valid_d = 1'b0;
            load_bubble  = 1'b1;
        end else if (redirect) begin
            // Squash the sequential fetch: one bubble per redirect.
            ifid_instr_d = NOP_WORD;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b0;
            load_bubble  = 1'b1;
        end else begin
            ifid_instr_d = Instruction_i;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            load_valid   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= TEXT_BASE;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign PC_o                = pc_q;
    assign IF_ID_Instruction_o = ifid_instr_q;
    assign IF_ID_PC_Plus4_o    = ifid_pc4_q;
    assign IF_ID_Valid_o       = ifid_valid_q;
    assign Fetch_Error_o       = fetch_err_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_valid && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (load_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Fetch_Count_o  = fetch_cnt_q;
    assign Bubble_Count_o = bubble_cnt_q;
`else
    logic unused_counters;
    assign unused_counters = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, stall, redirects,
// fault detection at both range edges, flush-during-stall and reset recovery.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall_i, Flush_i, Branch_Taken_i, Jump_i, Jump_Reg_i;
    logic [31:0] Branch_Target_i, Jump_Reg_Addr_i, Instruction_i;
    logic [25:0] Jump_Index_i;
    logic [31:0] PC_o, IF_ID_Instruction_o, IF_ID_PC_Plus4_o;
    logic        IF_ID_Valid_o, Fetch_Error_o;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] Fetch_Count_o, Bubble_Count_o;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall_i             (Stall_i),
        .Flush_i             (Flush_i),
        .Branch_Taken_i      (Branch_Taken_i),
        .Branch_Target_i     (Branch_Target_i),
        .Jump_i              (Jump_i),
        .Jump_Index_i        (Jump_Index_i),
        .Jump_Reg_i          (Jump_Reg_i),
        .Jump_Reg_Addr_i     (Jump_Reg_Addr_i),
        .Instruction_i       (Instruction_i),
        .PC_o                (PC_o),
        .IF_ID_Instruction_o (IF_ID_Instruction_o),
        .IF_ID_PC_Plus4_o    (IF_ID_PC_Plus4_o),
        .IF_ID_Valid_o       (IF_ID_Valid_o),
`ifdef FETCH_PERF_COUNTERS_EN
        .Fetch_Count_o       (Fetch_Count_o),
        .Bubble_Count_o      (Bubble_Count_o),
`endif
        .Fetch_Error_o       (Fetch_Error_o)
    );

    // Program memory model: four fixed words, otherwise 0x8C concatenated with the low address bits.
    always_comb begin
        case (PC_o)
            32'h0040_0000: Instruction_i = 32'h2008_0005;
            32'h0040_0004: Instruction_i = 32'h2009_0003;
            32'h0040_0008: Instruction_i = 32'h200A_0007;
            32'h0040_000C: Instruction_i = 32'h200B_0001;
            default:       Instruction_i = {8'h8C, PC_o[23:0]};
        endcase
    end

    task automatic step(input string what);
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d %s: pc=%h ifid=%h pc4=%h v=%0b err=%0b", cycle, what,
                 PC_o, IF_ID_Instruction_o, IF_ID_PC_Plus4_o, IF_ID_Valid_o, Fetch_Error_o);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] pc4, input logic v, input logic err);
        chk({tag, ".pc"}, PC_o, pc);
        chk({tag, ".instr"}, IF_ID_Instruction_o, ins);
        chk({tag, ".pc4"}, IF_ID_PC_Plus4_o, pc4);
        chk({tag, ".valid"}, {31'd0, IF_ID_Valid_o}, {31'd0, v});
        chk({tag, ".err"}, {31'd0, Fetch_Error_o}, {31'd0, err});
    endtask

    initial begin
        reset = 1'b0; Stall_i = 1'b0; Flush_i = 1'b0;
        Branch_Taken_i = 1'b0; Branch_Target_i = '0;
        Jump_i = 1'b0; Jump_Index_i = '0; Jump_Reg_i = 1'b0; Jump_Reg_Addr_i = '0;

        step("reset");
        chk_state("rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("rst.fcnt", Fetch_Count_o, 32'd0);
        chk("rst.bcnt", Bubble_Count_o, 32'd0);
`endif
        reset = 1'b1;

        // Sequential fetch
        step("seq0");
        chk_state("seq0", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 1'b0);
        step("seq1");
        chk_state("seq1", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1'b1, 1'b0);

        // Stall two cycles at 0x00400008
        Stall_i = 1'b1;
        step("stall0");
        chk_state("stall0", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1'b1, 1'b0);
        step("stall1");
        chk_state("stall1", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1'b1, 1'b0);
        Stall_i = 1'b0;
        step("unstall");
        chk_state("unstall", 32'h0040_000C, 32'h200A_0007, 32'h0040_000C, 1'b1, 1'b0);
        step("seq2");
        chk_state("seq2", 32'h0040_0010, 32'h200B_0001, 32'h0040_0010, 1'b1, 1'b0);

        // Taken branch at 0x00400010
        Branch_Taken_i = 1'b1; Branch_Target_i = 32'h0040_0020;
        step("branch");
        chk_state("branch", 32'h0040_0020, 32'h0, 32'h0040_0014, 1'b0, 1'b0);
        Branch_Taken_i = 1'b0;
        step("br_tgt");
        chk_state("br_tgt", 32'h0040_0024, 32'h8C40_0020, 32'h0040_0024, 1'b1, 1'b0);

        // All redirects at once: JR wins
        Jump_Reg_i = 1'b1; Jump_Reg_Addr_i = 32'h0040_0040;
        Jump_i = 1'b1; Jump_Index_i = 26'h010_0020;
        Branch_Taken_i = 1'b1; Branch_Target_i = 32'h0040_0060;
        step("jr_wins");
        chk_state("jr_wins", 32'h0040_0040, 32'h0, 32'h0040_0028, 1'b0, 1'b0);
        Stall_i = 1'b1;
        step("redir_stall");
        chk_state("redir_stall", 32'h0040_0040, 32'h0, 32'h0040_0028, 1'b0, 1'b0);
        Stall_i = 1'b0; Jump_Reg_i = 1'b0; Jump_i = 1'b0; Branch_Taken_i = 1'b0;
        step("after_jr");
        chk_state("after_jr", 32'h0040_0044, 32'h8C40_0040, 32'h0040_0044, 1'b1, 1'b0);

        // Plain J: target uses upper bits of IF/ID PC+4 (0) and index 0x0100020
        Jump_i = 1'b1;
        step("jump");
        chk_state("jump", 32'h0040_0080, 32'h0, 32'h0040_0048, 1'b0, 1'b0);
        Jump_i = 1'b0;

        // Misaligned JR target faults on the following edge
        Jump_Reg_i = 1'b1; Jump_Reg_Addr_i = 32'h0040_0102;
        step("jr_mis");
        chk_state("jr_mis", 32'h0040_0102, 32'h0, 32'h0040_0084, 1'b0, 1'b0);
        Jump_Reg_i = 1'b0;
        step("fault");
        chk_state("fault", 32'h0040_0102, 32'h0, 32'h0040_0084, 1'b0, 1'b1);
        step("fault_hold");
        chk_state("fault_hold", 32'h0040_0102, 32'h0, 32'h0040_0084, 1'b0, 1'b1);

        reset = 1'b0;
        step("rst2");
        chk_state("rst2", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;

        // Last legal word, then the first address past the end
        Jump_Reg_i = 1'b1; Jump_Reg_Addr_i = 32'h0040_00FC;
        step("jr_last");
        chk_state("jr_last", 32'h0040_00FC, 32'h0, 32'h0040_0004, 1'b0, 1'b0);
        Jump_Reg_i = 1'b0;
        step("last_ok");
        chk_state("last_ok", 32'h0040_0100, 32'h8C40_00FC, 32'h0040_0100, 1'b1, 1'b0);
        step("oor");
        chk_state("oor", 32'h0040_0100, 32'h0, 32'h0040_0100, 1'b0, 1'b1);

        reset = 1'b0;
        step("rst3");
        chk_state("rst3", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;

        // Flush during stall
        step("pre_flush");
        chk_state("pre_flush", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 1'b0);
        Flush_i = 1'b1; Stall_i = 1'b1;
        step("flush_stall");
        chk("flush_stall.pc", PC_o, 32'h0040_0004);
        chk("flush_stall.instr", IF_ID_Instruction_o, 32'h0);
        chk("flush_stall.valid", {31'd0, IF_ID_Valid_o}, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("flush_stall.fcnt", Fetch_Count_o, 32'd1);
        chk("flush_stall.bcnt", Bubble_Count_o, 32'd1);
`endif
        Flush_i = 1'b0; Stall_i = 1'b0;
        step("post_flush");
        chk_state("post_flush", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1'b1, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("post_flush.fcnt", Fetch_Count_o, 32'd2);
        chk("post_flush.bcnt", Bubble_Count_o, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the MIPS core, directly upstream of the program memory. It owns the program counter, drives the instruction-memory word address, and selects the next PC from sequential, branch, jump and jump-register sources. The instruction returned by the memory in the same cycle is captured into the IF/ID pipeline register, which supports stall, flush and out-of-range fetch detection.

Parameters:
DATA_WIDTH, 32, PC, address and instruction width.
TEXT_BASE, 32'h0040_0000, reset PC and lowest legal fetch address.
MEMORY_DEPTH, 64, number of instruction words; legal range is [TEXT_BASE, TEXT_BASE + 4*MEMORY_DEPTH).
NOP_WORD, 32'h0000_0000, word loaded into IF/ID on flush, squash or error.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
Stall_i  input  1  hold the PC and IF/ID register
Flush_i  input  1  load NOP_WORD into IF/ID
Branch_Taken_i  input  1  taken branch resolved in ID
Branch_Target_i  input  32  branch target address
Jump_i  input  1  J/JAL in ID
Jump_Index_i  input  26  instr_index field of the jump
Jump_Reg_i  input  1  JR in ID
Jump_Reg_Addr_i  input  32  rs value for JR
Instruction_i  input  32  combinational instruction from program memory for PC_o
PC_o  output  32  current PC to program memory
IF_ID_Instruction_o  output  32  latched instruction
IF_ID_PC_Plus4_o  output  32  latched PC+4 of that instruction
IF_ID_Valid_o  output  1  IF/ID holds a real instruction
Fetch_Error_o  output  1  sticky fetch fault

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-low: when reset=0 at a clock edge, the block resets.
- Reset values: PC_o=TEXT_BASE, IF_ID_Instruction_o=NOP_WORD, IF_ID_PC_Plus4_o=0, IF_ID_Valid_o=0, Fetch_Error_o=0.
- Reset overrides every other input.
- PC_plus4 = PC_o + 4, computed modulo 2^32. Wrap-around is not special-cased; the range check catches it.
- Jump target = {IF_ID_PC_Plus4_o[31:28], Jump_Index_i, 2'b00}.
- Next-PC priority, highest first:
  - Fetch_Error_o=1: hold PC.
  - Stall_i: hold PC.
  - Jump_Reg_i: Jump_Reg_Addr_i.
  - Jump_i: jump target.
  - Branch_Taken_i: Branch_Target_i.
  - Otherwise: PC_plus4.
- A redirect is any of Jump_Reg_i, Jump_i or Branch_Taken_i with Stall_i=0.
- A redirect squashes the sequentially fetched instruction:
  - IF/ID loads NOP_WORD and Valid=0.
  - IF_ID_PC_Plus4_o loads PC_plus4.
  - This gives a 1-bubble redirect penalty.
- Redirect inputs asserted during Stall_i are ignored. The controller must hold them until the stall drops.
- IF/ID update priority, highest first:
  1. Flush_i: loads NOP, Valid=0. This applies even during a stall; the PC is still held if Stall_i=1.
  2. Stall_i: holds.
  3. Fault: loads NOP, Valid=0.
  4. Redirect: loads NOP, Valid=0.
  5. Normal: loads {Instruction_i, PC_plus4} with Valid=1.
- Fault condition is evaluated combinationally on the current PC_o: PC_o[1:0]!=0, PC_o<TEXT_BASE, or PC_o>=TEXT_BASE+4*MEMORY_DEPTH.
- On a fault at an edge without stall:
  - Fetch_Error_o sets and stays set until reset.
  - PC freezes at the faulting value.
  - IF/ID receives NOP.
- A fault is not recorded while Stall_i=1.
- Latency: the instruction at PC_o appears on IF_ID_Instruction_o 1 cycle later. Back-to-back fetch sustains 1 instruction/cycle.
- Reset mid-operation, including during a stall or fault, restores all reset values on that edge.

Optional Feature:
FETCH_PERF_COUNTERS_EN:
- When defined, adds two outputs, Fetch_Count_o (32) and Bubble_Count_o (32). Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Fetch_Count_o increments on each edge where IF/ID loads with Valid=1.
- Bubble_Count_o increments on each edge where IF/ID loads with Valid=0 because of flush, fault or redirect. Stall edges are not counted.
- When not defined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset then free-run 4 cycles with Instruction_i = 32'h2008_0005, 32'h2009_0003, … → PC_o steps 0x00400000, 04, 08, 0C; IF/ID shows each word one cycle later with Valid=1 and PC_Plus4 = 0x00400004, 0x00400008, ….
2. Stall_i=1 for 2 cycles at PC 0x00400008 → PC_o and IF/ID hold both cycles; on release PC goes to 0x0040000C and IF/ID loads the 0x00400008 word.
3. Branch_Taken_i=1 with Branch_Target_i=0x00400020 at PC 0x00400010 → next PC 0x00400020; IF/ID gets NOP with Valid=0; the following cycle IF/ID Valid=1 with PC_Plus4 0x00400024.
4. Jump_i, Jump_Reg_i and Branch_Taken_i all asserted in the same cycle, with Jump_Reg_Addr_i=0x00400040 → PC goes to 0x00400040 (JR wins). Repeat with Stall_i=1 → PC is unchanged.
5. Jump_Reg_Addr_i=0x00400102 → next cycle Fetch_Error_o=1 from the misaligned address, PC frozen at 0x00400102, IF/ID NOP. Then reset=0 for one edge → PC=0x00400000 and error cleared.
6. Flush_i=1 together with Stall_i=1 → IF/ID becomes NOP with Valid=0 and PC is held. With FETCH_PERF_COUNTERS_EN defined, Bubble_Count_o increments by 1 and Fetch_Count_o is unchanged.
